// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies a synchronised LOCK as
// stable, then releases downstream reset. Lock timeouts and unstable locks
// are retried a bounded number of times before falling back to bypass.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RST    | PLL held in reset for RESET_CYCLES, downstream in reset
// ST_WAIT   | PLL released, waiting for synchronised lock (with timeout)
// ST_STABLE | counting consecutive lock cycles before declaring good
// ST_RUN    | clock good, downstream reset released
// ST_FLT    | retries exhausted, running on bypassed reference clock
// ST_BYP    | forced bypass requested by FORCE_BYPASS
module pll_lock_supervisor #(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 16,
  parameter int RETRY_W            = 2
) (
  input  logic               REFERENCECLK,
  input  logic               RESET,
  input  logic               PLL_LOCK,
  input  logic               FORCE_BYPASS,
  input  logic               CLEAR_FAULT,
  output logic               PLL_RESETB,
  output logic               PLL_BYPASS,
  output logic               SYS_RESET,
  output logic               CLK_GOOD,
  output logic               LOCK_LOST,
  output logic               FAULT,
  output logic [RETRY_W-1:0] RETRY_COUNT
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FLT    = 3'd4,
    ST_BYP    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     timer, timer_nxt, timer_inc;
  logic [RETRY_W-1:0]   retry_nxt;
  logic [1:0]           lock_sync;
  logic                 lock_s;
  logic                 fail;
  logic                 lost_evt;
  logic                 resetb_nxt, bypass_nxt, sys_reset_nxt;
  logic                 clk_good_nxt, lock_lost_nxt, fault_nxt;

  assign lock_s    = lock_sync[1];
  // Timer saturates rather than wrapping so a stuck state never re-arms a compare.
  assign timer_inc = (timer == CNT_MAX) ? timer : timer + CNT_W'(1);

  // Two-flop synchroniser for the asynchronous PLL LOCK output.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) lock_sync <= '0;
    else       lock_sync <= {lock_sync[0], PLL_LOCK};
  end

  // State, timer, retry counter and registered outputs.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state       <= ST_RST;
      timer       <= '0;
      RETRY_COUNT <= '0;
      PLL_RESETB  <= 1'b0;
      PLL_BYPASS  <= 1'b0;
      SYS_RESET   <= 1'b1;
      CLK_GOOD    <= 1'b0;
      LOCK_LOST   <= 1'b0;
      FAULT       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      RETRY_COUNT <= retry_nxt;
      PLL_RESETB  <= resetb_nxt;
      PLL_BYPASS  <= bypass_nxt;
      SYS_RESET   <= sys_reset_nxt;
      CLK_GOOD    <= clk_good_nxt;
      LOCK_LOST   <= lock_lost_nxt;
      FAULT       <= fault_nxt;
    end
  end

  // Next state, timer and retry count; forced bypass overrides the sequencer.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer_inc;
    retry_nxt = RETRY_COUNT;
    fail      = 1'b0;
    lost_evt  = 1'b0;
    if (FORCE_BYPASS) begin
      state_nxt = ST_BYP;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_RST: begin
          if (timer >= RST_LAST) begin
            state_nxt = ST_WAIT;
            timer_nxt = '0;
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            timer_nxt = '0;
          end else if (timer >= TO_LAST) begin
            fail = 1'b1;
          end
        end
        ST_STABLE: begin
          // A lock drop on the completing cycle still counts as a failure.
          if (!lock_s) begin
            fail = 1'b1;
          end else if (timer >= STB_LAST) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
            retry_nxt = '0;
          end
        end
        ST_RUN: begin
          timer_nxt = '0;
          if (!lock_s) begin
            state_nxt = ST_RST;
            lost_evt  = 1'b1;
          end
        end
        ST_FLT: begin
          timer_nxt = '0;
          if (CLEAR_FAULT) begin
            state_nxt = ST_RST;
            retry_nxt = '0;
          end
        end
        ST_BYP: begin
          timer_nxt = '0;
          state_nxt = FAULT ? ST_FLT : ST_RST;
        end
        default: begin
          state_nxt = ST_RST;
          timer_nxt = '0;
        end
      endcase
      if (fail) begin
        timer_nxt = '0;
        if (RETRY_COUNT < RETRY_MAX) begin
          retry_nxt = RETRY_COUNT + RETRY_W'(1);
          state_nxt = ST_RST;
        end else begin
          state_nxt = ST_FLT;
        end
      end
    end
  end

  // Output values for the state being entered, registered on the same edge.
  always_comb begin
    resetb_nxt    = (state_nxt == ST_WAIT) || (state_nxt == ST_STABLE) ||
                    (state_nxt == ST_RUN);
    bypass_nxt    = (state_nxt == ST_FLT) || (state_nxt == ST_BYP);
    sys_reset_nxt = (state_nxt == ST_RST) || (state_nxt == ST_WAIT) ||
                    (state_nxt == ST_STABLE);
    clk_good_nxt  = (state_nxt == ST_RUN);
    fault_nxt     = (state_nxt == ST_FLT) || ((state_nxt == ST_BYP) && FAULT);
    lock_lost_nxt = LOCK_LOST || lost_evt;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output vectors are
// queued with the cycle they are due and compared on the falling edge.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       fbyp = 1'b0;
  logic       clr = 1'b0;
  logic       pll_resetb, pll_bypass, sys_reset, clk_good, lock_lost, fault;
  logic [1:0] retry;

  int cyc   = 0;
  int base  = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
    string      tag;
  } exp_t;
  exp_t sb[$];

  pll_lock_supervisor #(
    .RESET_CYCLES      (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2),
    .CNT_W             (16),
    .RETRY_W           (2)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (rst),
    .PLL_LOCK    (lock),
    .FORCE_BYPASS(fbyp),
    .CLEAR_FAULT (clr),
    .PLL_RESETB  (pll_resetb),
    .PLL_BYPASS  (pll_bypass),
    .SYS_RESET   (sys_reset),
    .CLK_GOOD    (clk_good),
    .LOCK_LOST   (lock_lost),
    .FAULT       (fault),
    .RETRY_COUNT (retry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [7:0] obs = {retry, fault, lock_lost, clk_good, sys_reset, pll_bypass, pll_resetb};

  function automatic logic [7:0] pk(input logic rb, input logic bp, input logic sr,
                                    input logic cg, input logic ll, input logic ft,
                                    input logic [1:0] rc);
    return {rc, ft, ll, cg, sr, bp, rb};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic expect_at(input int off, input logic [7:0] v, input string tag);
    exp_t e;
    e.due = base + off;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Pop every expectation due after the most recent rising edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_val(sb[i].tag, {24'd0, obs}, {24'd0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int off);
    while (cyc < base + off) step();
  endtask

  // One reset edge; base marks that edge, inputs driven now are sampled at base+1.
  task automatic do_reset(input logic lk);
    rst  = 1'b1;
    lock = lk;
    fbyp = 1'b0;
    clr  = 1'b0;
    step();
    base = cyc;
    rst  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step();

    // Lock-up from reset, then a one-cycle lock drop in RUN.
    do_reset(1'b0);
    expect_at(0,  pk(0,0,1,0,0,0,0), "s1_reset_vals");
    expect_at(3,  pk(0,0,1,0,0,0,0), "s1_rstb_low_last");
    expect_at(4,  pk(1,0,1,0,0,0,0), "s1_rstb_rise");
    expect_at(19, pk(1,0,1,0,0,0,0), "s1_pre_good");
    expect_at(20, pk(1,0,0,1,0,0,0), "s1_clk_good");
    expect_at(26, pk(1,0,0,1,0,0,0), "s3_still_run");
    expect_at(27, pk(0,0,1,0,1,0,0), "s3_lock_drop");
    expect_at(31, pk(1,0,1,0,1,0,0), "s3_rewait");
    expect_at(39, pk(1,0,1,0,1,0,0), "s3_pre_relock");
    expect_at(40, pk(1,0,0,1,1,0,0), "s3_relock_lost_sticky");
    run_to(9);
    lock = 1'b1;
    run_to(24);
    lock = 1'b0;
    step();
    lock = 1'b1;
    run_to(45);

    // One-cycle reset in RUN with lock held high.
    do_reset(1'b1);
    expect_at(0,  pk(0,0,1,0,0,0,0), "s6_reset_vals");
    expect_at(3,  pk(0,0,1,0,0,0,0), "s6_rstb_low");
    expect_at(4,  pk(1,0,1,0,0,0,0), "s6_wait");
    expect_at(12, pk(1,0,1,0,0,0,0), "s6_pre_good");
    expect_at(13, pk(1,0,0,1,0,0,0), "s6_clk_good");
    run_to(16);

    // Lock glitch during STABLE.
    do_reset(1'b1);
    expect_at(9,  pk(1,0,1,0,0,0,0), "s4_stable");
    expect_at(10, pk(0,0,1,0,0,0,1), "s4_glitch_fail");
    expect_at(12, pk(0,0,1,0,0,0,1), "s4_rst_retry");
    expect_at(14, pk(1,0,1,0,0,0,1), "s4_rewait");
    expect_at(22, pk(1,0,1,0,0,0,1), "s4_pre_good");
    expect_at(23, pk(1,0,0,1,0,0,0), "s4_good_retry_clr");
    run_to(7);
    lock = 1'b0;
    step();
    lock = 1'b1;
    run_to(26);

    // Forced bypass during WAIT.
    do_reset(1'b0);
    expect_at(8,  pk(1,0,1,0,0,0,0), "s5_wait");
    expect_at(9,  pk(0,1,0,0,0,0,0), "s5_bypass");
    expect_at(18, pk(0,1,0,0,0,0,0), "s5_bypass_hold");
    expect_at(19, pk(0,0,1,0,0,0,0), "s5_release_rst");
    expect_at(22, pk(0,0,1,0,0,0,0), "s5_rst_last");
    expect_at(23, pk(1,0,1,0,0,0,0), "s5_rewait");
    expect_at(33, pk(1,0,1,0,0,0,0), "s5_pre_good");
    expect_at(34, pk(1,0,0,1,0,0,0), "s5_clk_good");
    run_to(8);
    fbyp = 1'b1;
    run_to(18);
    fbyp = 1'b0;
    run_to(23);
    lock = 1'b1;
    run_to(37);

    // Lock never comes: retries, fault, bypass in fault, clear.
    do_reset(1'b0);
    expect_at(3,  pk(0,0,1,0,0,0,0), "s2_p1_low");
    expect_at(4,  pk(1,0,1,0,0,0,0), "s2_p1_end");
    expect_at(23, pk(1,0,1,0,0,0,0), "s2_w1_last");
    expect_at(24, pk(0,0,1,0,0,0,1), "s2_retry1");
    expect_at(28, pk(1,0,1,0,0,0,1), "s2_p2_end");
    expect_at(36, pk(1,0,1,0,0,0,1), "s2_clr_ignored");
    expect_at(48, pk(0,0,1,0,0,0,2), "s2_retry2");
    expect_at(52, pk(1,0,1,0,0,0,2), "s2_p3_end");
    expect_at(71, pk(1,0,1,0,0,0,2), "s2_w3_last");
    expect_at(72, pk(0,1,0,0,0,1,2), "s2_fault");
    expect_at(76, pk(0,1,0,0,0,1,2), "s2_byp_keeps_fault");
    expect_at(79, pk(0,1,0,0,0,1,2), "s2_back_to_flt");
    expect_at(82, pk(0,1,0,0,0,1,2), "s2_flt_hold");
    expect_at(85, pk(0,0,1,0,0,0,0), "s2_clear");
    expect_at(88, pk(0,0,1,0,0,0,0), "s2_new_low");
    expect_at(89, pk(1,0,1,0,0,0,0), "s2_new_pulse_end");
    run_to(35);
    clr = 1'b1;
    step();
    clr = 1'b0;
    run_to(75);
    fbyp = 1'b1;
    clr  = 1'b1;
    step();
    clr  = 1'b0;
    run_to(78);
    fbyp = 1'b0;
    run_to(84);
    clr = 1'b1;
    step();
    clr = 1'b0;
    run_to(92);

    check_val("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the iCE40 PLL (PLL_SECONDARY) on the reference clock. It pulses the PLL reset, waits for LOCK and qualifies it as stable before releasing downstream reset and flagging the clock good. On lock loss or timeout it retries a bounded number of times. After the retries are exhausted it falls back to BYPASS so the VGA pipeline still receives a clock.

Parameters:
RESET_CYCLES, 16, cycles PLL_RESETB held low per attempt (>=1)
LOCK_TIMEOUT, 65535, max cycles waiting for synchronised lock per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before run (>=1)
MAX_RETRIES, 3, failed attempts retried before fault (0..2^RETRY_W-1)
CNT_W, 16, shared timer width; must hold max of the three cycle parameters
RETRY_W, 2, width of RETRY_COUNT

Ports:
REFERENCECLK  in   1        sole clock, PLL reference clock
RESET         in   1        synchronous, active-high
PLL_LOCK      in   1        PLL LOCK output, asynchronous to REFERENCECLK
FORCE_BYPASS  in   1        level request: run on bypassed reference clock
CLEAR_FAULT   in   1        single-cycle pulse, leaves FAULT state
PLL_RESETB    out  1        to PLL RESETB, active-low
PLL_BYPASS    out  1        to PLL BYPASS
SYS_RESET     out  1        downstream reset, active-high
CLK_GOOD      out  1        PLL output locked and qualified
LOCK_LOST     out  1        sticky: lock dropped while in RUN
FAULT         out  1        retries exhausted, running bypassed
RETRY_COUNT   out  RETRY_W  failed attempts since last successful lock

Behaviour:
- All outputs registered. A transition decided at edge N takes effect in the outputs after edge N.
- RESET (sampled high) values: state RST, timer 0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESET=1, CLK_GOOD=0, LOCK_LOST=0, FAULT=0, RETRY_COUNT=0, sync flops 0. RESET mid-operation aborts immediately to these values.
- PLL_LOCK passes through a 2-flop synchroniser (lock_s). All decisions use lock_s, which adds 2 cycles of latency.
- Priority: RESET > FORCE_BYPASS > state logic.
- States:
  - RST: PLL_RESETB=0, SYS_RESET=1, CLK_GOOD=0. Timer counts 0..RESET_CYCLES-1, then go to WAIT with timer cleared. PLL_RESETB is low for exactly RESET_CYCLES cycles.
  - WAIT: PLL_RESETB=1. lock_s=1 -> STABLE, timer=0. Timer reaching LOCK_TIMEOUT-1 with lock_s=0 -> FAIL path.
  - STABLE: timer counts consecutive lock_s=1 cycles.
    - lock_s=0 -> FAIL path.
    - timer==LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN. CLK_GOOD=1, SYS_RESET=0 and RETRY_COUNT=0 take effect on the transition edge.
  - RUN: PLL_RESETB=1, CLK_GOOD=1, SYS_RESET=0. On lock_s=0: LOCK_LOST<=1, CLK_GOOD<=0, SYS_RESET<=1, go to RST. This does not count as a retry.
  - FAIL path (not a state): if RETRY_COUNT<MAX_RETRIES then RETRY_COUNT+1 and go to RST. Otherwise go to FLT.
  - FLT: FAULT=1, PLL_BYPASS=1, PLL_RESETB=0, SYS_RESET=0, CLK_GOOD=0. Stays until CLEAR_FAULT, which sets FAULT<=0 and RETRY_COUNT<=0 and goes to RST. CLEAR_FAULT outside FLT is ignored.
  - BYP: entered from any state while FORCE_BYPASS=1.
    - PLL_BYPASS=1, PLL_RESETB=0, SYS_RESET=0, CLK_GOOD=0. FAULT keeps its value.
    - On FORCE_BYPASS=0: go to FLT if FAULT=1, else go to RST with timer cleared.
- LOCK_LOST clears only on RESET. It is unaffected by CLEAR_FAULT.
- The timer never wraps; it saturates at 2^CNT_W-1.
- Simultaneous events:
  - Lock drop in the same cycle STABLE would complete -> FAIL.
  - CLEAR_FAULT together with FORCE_BYPASS -> BYP wins and FAULT is retained.

Test Plan:
(All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.)
1. Release RESET, then raise PLL_LOCK 5 cycles after PLL_RESETB rises -> PLL_RESETB low exactly 4 cycles. CLK_GOOD=1 and SYS_RESET=0 exactly 10 cycles after the PLL_LOCK rise. RETRY_COUNT=0.
2. PLL_LOCK tied 0 -> three PLL_RESETB low pulses of 4 cycles each, separated by 20-cycle waits. RETRY_COUNT goes 1, then 2. FAULT=1 and PLL_BYPASS=1 with SYS_RESET=0 at 72 cycles after RESET release. CLEAR_FAULT pulse -> FAULT=0, RETRY_COUNT=0, new 4-cycle PLL_RESETB pulse.
3. In RUN, drop PLL_LOCK for 1 cycle -> SYS_RESET=1 and CLK_GOOD=0 3 cycles after the drop. LOCK_LOST=1 and stays 1 after relock and CLK_GOOD returns.
4. PLL_LOCK glitches low at cycle 5 of STABLE -> RETRY_COUNT=1 and re-sequence from RST. CLK_GOOD never asserts during the glitch attempt.
5. Assert FORCE_BYPASS mid-WAIT, hold 10 cycles -> next cycle PLL_BYPASS=1, PLL_RESETB=0, SYS_RESET=0. On release -> full RST (4 cycles) and lock sequence. With FORCE_BYPASS during FLT, release -> returns to FLT with FAULT=1.
6. Assert RESET for 1 cycle during RUN -> all outputs at reset values after the next edge, then the normal sequence from scenario 1.
